mem_bus_arbiter: RTL and testbench

//  Two-master arbiter for the single external memory bus (db_* signals) leaving the CPU.
//  m0 = instruction-side cache/MMU path, m1 = data-side cache/MMU path; both see a
//  db-style read/write/ready interface. Round-robin grant with burst lock so a cache

---
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the external memory bus: round-robin grant, burst lock that keeps a
// line fill/writeback on one master, and a watchdog that aborts words the slave never acks.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_WIDTH       = 8
) (
  input  logic        clk,
  input  logic        res,

  input  logic        m0_re,
  input  logic        m0_we,
  input  logic        m0_io,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_dataOut,
  output logic [31:0] m0_dataIn,
  output logic        m0_ready,
  output logic        m0_err,

  input  logic        m1_re,
  input  logic        m1_we,
  input  logic        m1_io,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_dataOut,
  output logic [31:0] m1_dataIn,
  output logic        m1_ready,
  output logic        m1_err,

  input  logic        db_ready,
  input  logic [31:0] db_dataIn,
  output logic [31:0] db_addr,
  output logic [31:0] db_dataOut,
  output logic        db_re,
  output logic        db_we,
  output logic        db_io
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StG0   = 2'd1;
  localparam logic [1:0] StG1   = 2'd2;

  localparam logic [TO_WIDTH-1:0] WdogLast = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]          r_state, w_state_d;
  logic                r_prio, w_prio_d;
  logic [TO_WIDTH-1:0] r_wdog, w_wdog_d;

  logic w_g0, w_g1, w_gnt;
  logic w_req0, w_req1, w_sel_req, w_oth_req, w_sel_lock;
  logic w_we_s, w_re_s, w_strobe, w_done, w_timeout, w_release;

  // Grants are masked by reset so nothing reaches the bus or the masters while res is low.
  assign w_g0  = res & (r_state == StG0);
  assign w_g1  = res & (r_state == StG1);
  assign w_gnt = w_g0 | w_g1;

  assign w_req0     = m0_re | m0_we;
  assign w_req1     = m1_re | m1_we;
  assign w_sel_req  = w_g1 ? w_req1 : w_req0;
  assign w_oth_req  = w_g1 ? w_req0 : w_req1;
  assign w_sel_lock = w_g1 ? m1_lock : m0_lock;

  // Write wins when a master raises both strobes.
  assign w_we_s   = w_gnt & (w_g1 ? m1_we : m0_we);
  assign w_re_s   = w_gnt & (w_g1 ? (m1_re & ~m1_we) : (m0_re & ~m0_we));
  assign w_strobe = w_we_s | w_re_s;

  assign w_done    = w_strobe & db_ready;
  assign w_timeout = w_strobe & ~db_ready & (r_wdog == WdogLast);
  assign w_release = w_gnt & ~w_sel_lock & (w_done | ~w_sel_req);

  assign db_re      = w_re_s & ~w_timeout;
  assign db_we      = w_we_s & ~w_timeout;
  assign db_io      = w_gnt & (w_g1 ? m1_io : m0_io);
  assign db_addr    = w_g0 ? m0_addr : (w_g1 ? m1_addr : 32'h0);
  assign db_dataOut = w_g0 ? m0_dataOut : (w_g1 ? m1_dataOut : 32'h0);

  assign m0_dataIn = db_dataIn;
  assign m1_dataIn = db_dataIn;
  assign m0_ready  = w_g0 & w_done;
  assign m1_ready  = w_g1 & w_done;
  assign m0_err    = w_g0 & w_timeout;
  assign m1_err    = w_g1 & w_timeout;

  always_comb begin
    w_state_d = r_state;
    w_prio_d  = r_prio;
    w_wdog_d  = r_wdog;
    case (r_state)
      StIdle: begin
        w_wdog_d = '0;
        if (w_req0 && w_req1) begin
          w_state_d = r_prio ? StG1 : StG0;
        end else if (w_req0) begin
          w_state_d = StG0;
        end else if (w_req1) begin
          w_state_d = StG1;
        end
      end
      StG0, StG1: begin
        if (w_timeout) begin
          w_state_d = StIdle;
          w_prio_d  = (r_state == StG0);
          w_wdog_d  = '0;
        end else if (w_release) begin
          // Hand straight to the other master if it is waiting, otherwise park in idle.
          w_prio_d  = (r_state == StG0);
          w_wdog_d  = '0;
          if (w_oth_req) begin
            w_state_d = (r_state == StG0) ? StG1 : StG0;
          end else begin
            w_state_d = StIdle;
          end
        end else if (w_done) begin
          w_wdog_d = '0;
        end else if (w_strobe) begin
          w_wdog_d = r_wdog + TO_WIDTH'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_wdog_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      r_state <= StIdle;
      r_prio  <= 1'b0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_d;
      r_prio  <= w_prio_d;
      r_wdog  <= w_wdog_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then randomized
// masters and slave stalls checked every cycle against an ownership-level model.
module tb_mem_bus_arbiter;

  localparam int TO_CYC = 8;

  logic        clk = 1'b0;
  logic        res;
  logic        m0_re, m0_we, m0_io, m0_lock, m1_re, m1_we, m1_io, m1_lock;
  logic [31:0] m0_addr, m0_dataOut, m1_addr, m1_dataOut;
  logic [31:0] m0_dataIn, m1_dataIn;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic        db_ready;
  logic [31:0] db_dataIn, db_addr, db_dataOut;
  logic        db_re, db_we, db_io;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .TO_WIDTH(4)) dut (
    .clk(clk), .res(res),
    .m0_re(m0_re), .m0_we(m0_we), .m0_io(m0_io), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_dataIn(m0_dataIn),
    .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_re(m1_re), .m1_we(m1_we), .m1_io(m1_io), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_dataIn(m1_dataIn),
    .m1_ready(m1_ready), .m1_err(m1_err),
    .db_ready(db_ready), .db_dataIn(db_dataIn), .db_addr(db_addr),
    .db_dataOut(db_dataOut), .db_re(db_re), .db_we(db_we), .db_io(db_io)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Master-side drive state, copied onto the DUT pins by apply().
  logic        mre[2], mwe[2], mio[2], mlk[2];
  logic [31:0] ma[2], md[2];

  task automatic apply();
    m0_re = mre[0]; m0_we = mwe[0]; m0_io = mio[0]; m0_lock = mlk[0];
    m0_addr = ma[0]; m0_dataOut = md[0];
    m1_re = mre[1]; m1_we = mwe[1]; m1_io = mio[1]; m1_lock = mlk[1];
    m1_addr = ma[1]; m1_dataOut = md[1];
  endtask

  task automatic clear_master(input int n);
    mre[n] = 1'b0; mwe[n] = 1'b0; mlk[n] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b0;
    tick();
    tick();
    res = 1'b1;
  endtask

  // Model: who owns the bus (-1 = nobody), who wins the next tie, how long the word has waited.
  int m_owner = -1, m_prio = 0, m_wait = 0;
  int nx_owner, nx_prio, nx_wait;
  bit have_nx = 0;
  bit started = 0;

  task automatic model_step();
    logic [1:0]  re, we, io, lk, rq;
    logic [31:0] ad[2], wd[2];
    logic [31:0] e_addr, e_dout;
    logic        e_re, e_we, e_io, strobe, to, done;
    logic [1:0]  e_rdy, e_err;
    int n, o;
    re = {m1_re, m0_re}; we = {m1_we, m0_we}; io = {m1_io, m0_io}; lk = {m1_lock, m0_lock};
    rq = re | we;
    ad[0] = m0_addr; ad[1] = m1_addr; wd[0] = m0_dataOut; wd[1] = m1_dataOut;
    e_addr = 0; e_dout = 0; e_re = 0; e_we = 0; e_io = 0; e_rdy = 0; e_err = 0;
    strobe = 0; to = 0; done = 0; n = 0;
    if (res && m_owner >= 0) begin
      n = m_owner;
      strobe = re[n] | we[n];
      to = strobe && !db_ready && (m_wait == TO_CYC - 1);
      done = strobe && db_ready;
      e_addr = ad[n]; e_dout = wd[n]; e_io = io[n];
      e_we = we[n] && !to;
      e_re = re[n] && !we[n] && !to;
      e_rdy[n] = done;
      e_err[n] = to;
    end
    check("db_addr", db_addr, e_addr);
    check("db_dataOut", db_dataOut, e_dout);
    check("db_re/we/io", {29'd0, db_re, db_we, db_io}, {29'd0, e_re, e_we, e_io});
    check("ready m1/m0", {30'd0, m1_ready, m0_ready}, {30'd0, e_rdy});
    check("err m1/m0", {30'd0, m1_err, m0_err}, {30'd0, e_err});
    check("m0_dataIn", m0_dataIn, db_dataIn);
    check("m1_dataIn", m1_dataIn, db_dataIn);
    nx_owner = m_owner; nx_prio = m_prio; nx_wait = m_wait;
    if (!res) begin
      nx_owner = -1; nx_prio = 0; nx_wait = 0;
    end else if (m_owner < 0) begin
      nx_wait = 0;
      if (rq[0] && rq[1]) nx_owner = m_prio;
      else if (rq[0]) nx_owner = 0;
      else if (rq[1]) nx_owner = 1;
    end else begin
      o = 1 - n;
      if (to) begin
        nx_owner = -1; nx_prio = o; nx_wait = 0;
      end else if ((done || !rq[n]) && !lk[n]) begin
        nx_prio = o; nx_wait = 0;
        nx_owner = rq[o] ? o : -1;
      end else if (done) begin
        nx_wait = 0;
      end else if (strobe) begin
        nx_wait = m_wait + 1;
      end
    end
    have_nx = 1;
  endtask

  always @(negedge clk) if (started) model_step();

  always @(posedge clk) begin
    if (have_nx) begin
      m_owner = nx_owner; m_prio = nx_prio; m_wait = nx_wait;
    end
    started = 1;
  end

  // Random-phase master bookkeeping.
  int  act[2], left[2], gap[2], kind[2];
  logic rs[2], es[2];
  int  stall;

  task automatic set_strobe(input int n);
    mre[n] = (kind[n] != 1);
    mwe[n] = (kind[n] != 0);
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      clear_master(n); mio[n] = 0; ma[n] = 0; md[n] = 0;
      act[n] = 0; left[n] = 0; gap[n] = 0; kind[n] = 0;
    end
    stall = 0;
    db_dataIn = 32'h1234_5678;

    // Reset holds the bus quiet even with a request pending.
    res = 1'b0; db_ready = 1'b1; mre[0] = 1; ma[0] = 32'h10; apply();
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      check("T1 db_re in reset", {31'd0, db_re}, 32'd0);
      check("T1 m0_ready in reset", {31'd0, m0_ready}, 32'd0);
    end
    tick(); res = 1'b1; @(negedge clk);
    check("T1 db_re first idle", {31'd0, db_re}, 32'd0);
    tick(); @(negedge clk);
    check("T1 db_re granted", {31'd0, db_re}, 32'd1);
    check("T1 db_addr", db_addr, 32'h10);
    tick(); clear_master(0); apply();

    // Tie from idle alternates m0, m1, m0, m1.
    do_reset();
    mre[0] = 1; ma[0] = 32'h100; mre[1] = 1; ma[1] = 32'h200; db_ready = 1; apply();
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk);
      check("T2 db_addr", db_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      check("T2 m0_ready", {31'd0, m0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    tick(); clear_master(0); clear_master(1); apply(); tick(); tick();

    // Four locked writes from m1 are never split by a waiting m0.
    do_reset();
    mwe[1] = 1; mlk[1] = 1; ma[1] = 32'h40; md[1] = 32'hA5A5_0000; db_ready = 1; apply();
    for (int w = 0; w < 4; w++) begin
      tick();
      ma[1] = 32'h40 + 32'(4 * w); mlk[1] = (w < 3); mre[0] = 1; ma[0] = 32'h300; apply();
      @(negedge clk);
      check("T3 db_addr burst", db_addr, 32'h40 + 32'(4 * w));
      check("T3 m1_ready", {31'd0, m1_ready}, 32'd1);
      check("T3 m0_ready held off", {31'd0, m0_ready}, 32'd0);
    end
    tick(); clear_master(1); apply(); @(negedge clk);
    check("T3 m0 handoff addr", db_addr, 32'h300);
    check("T3 m0 handoff re", {31'd0, db_re}, 32'd1);
    tick(); clear_master(0); apply(); tick(); tick();

    // Write wins over read.
    mwe[0] = 1; mre[0] = 1; md[0] = 32'hDEAD_BEEF; ma[0] = 32'h80; db_ready = 0; apply();
    tick(); @(negedge clk);
    check("T4 db_we", {31'd0, db_we}, 32'd1);
    check("T4 db_re", {31'd0, db_re}, 32'd0);
    check("T4 db_dataOut", db_dataOut, 32'hDEAD_BEEF);
    tick(); clear_master(0); apply(); tick(); tick();

    // Watchdog abort on an unacknowledged read, then the waiting master gets the bus.
    do_reset();
    mre[1] = 1; ma[1] = 32'h500; db_ready = 0; apply();
    tick(); mre[0] = 1; ma[0] = 32'h600; apply();
    for (int c = 0; c < TO_CYC; c++) begin
      @(negedge clk);
      check("T5 db_re while waiting", {31'd0, db_re}, (c < TO_CYC - 1) ? 32'd1 : 32'd0);
      check("T5 m1_err", {31'd0, m1_err}, (c == TO_CYC - 1) ? 32'd1 : 32'd0);
      tick();
    end
    clear_master(1); apply(); @(negedge clk);
    check("T5 idle after abort", {31'd0, db_re}, 32'd0);
    tick(); db_ready = 1; apply(); @(negedge clk);
    check("T5 m0 granted addr", db_addr, 32'h600);
    check("T5 m0_ready", {31'd0, m0_ready}, 32'd1);
    tick(); clear_master(0); apply(); tick();

    // Reset in the middle of an m0 burst: no pulses, tie priority back to m0.
    mre[0] = 1; mlk[0] = 1; ma[0] = 32'h700; db_ready = 1; apply();
    tick(); @(negedge clk);
    check("T6 m0_ready first word", {31'd0, m0_ready}, 32'd1);
    tick(); res = 1'b0; apply(); @(negedge clk);
    check("T6 m0_ready in reset", {31'd0, m0_ready}, 32'd0);
    check("T6 m0_err in reset", {31'd0, m0_err}, 32'd0);
    tick(); res = 1'b1; mre[1] = 1; ma[1] = 32'h800; apply(); @(negedge clk);
    check("T6 idle after reset", {31'd0, db_re}, 32'd0);
    tick(); @(negedge clk);
    check("T6 tie goes to m0", db_addr, 32'h700);
    tick(); clear_master(0); clear_master(1); apply(); tick(); tick();

    // Randomized masters with bursts, gaps, both strobes, slave stalls and stray resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rs[0] = m0_ready; rs[1] = m1_ready; es[0] = m0_err; es[1] = m1_err;
      tick();
      res = ($urandom_range(0, 199) != 0);
      for (int n = 0; n < 2; n++) begin
        if (act[n] != 0 && es[n]) begin
          act[n] = 0; clear_master(n);
        end else if (act[n] != 0 && gap[n] != 0) begin
          gap[n] = 0; set_strobe(n);
        end else if (act[n] != 0 && rs[n]) begin
          if (left[n] > 0) begin
            left[n]--; ma[n] = ma[n] + 32'd4; md[n] = $urandom; mlk[n] = (left[n] > 0);
            if (mlk[n] && $urandom_range(0, 3) == 0) begin
              gap[n] = 1; mre[n] = 0; mwe[n] = 0;
            end
          end else begin
            act[n] = 0; clear_master(n);
          end
        end else if (act[n] == 0 && $urandom_range(0, 3) == 0) begin
          act[n] = 1; left[n] = $urandom_range(0, 3); kind[n] = $urandom_range(0, 2);
          ma[n] = $urandom & 32'hFFFF_FFFC; md[n] = $urandom; mio[n] = 1'($urandom_range(0, 1));
          mlk[n] = (left[n] > 0); set_strobe(n);
        end
      end
      if (stall > 0) begin
        db_ready = 0; stall--;
      end else begin
        db_ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 39) == 0) stall = 10;
      end
      db_dataIn = $urandom;
      apply();
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
